// File: rtl/gray_window3x3_if.sv
// rtl/gray_window3x3_if.sv - pixel-in / luma-window-out signal bundle for gray_window3x3
interface gray_window3x3_if;
    logic [23:0] i_img;
    logic        i_valid;
    logic [71:0] o_window;
    logic        o_valid;
    logic        o_frame_done;

    modport master (
        output i_img,
        output i_valid,
        input  o_window,
        input  o_valid,
        input  o_frame_done
    );

    modport slave (
        input  i_img,
        input  i_valid,
        output o_window,
        output o_valid,
        output o_frame_done
    );
endinterface

// File: rtl/gray_window3x3.sv
// rtl/gray_window3x3.sv - RGB to luma conversion with two luma line memories emitting interior 3x3 windows
module gray_window3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             reset,
    gray_window3x3_if.slave  bus
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    g;
    logic          g_valid;
    logic [CW-1:0] g_col;
    logic [RW-1:0] g_row;
    logic [15:0]   luma_sum;

    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [23:0]   col_mid;
    logic [23:0]   col_right;
    logic [23:0]   col_new;
    logic [71:0]   win_next;
    logic          emit;
    logic          last_pix;

    always_comb begin
        luma_sum = 16'd77  * {8'd0, bus.i_img[23:16]}
                 + 16'd150 * {8'd0, bus.i_img[15:8]}
                 + 16'd29  * {8'd0, bus.i_img[7:0]};
    end

    // Stage 1: luma plus the raster position of the pixel it came from
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            g       <= '0;
            g_valid <= 1'b0;
            g_col   <= '0;
            g_row   <= '0;
        end else begin
            g_valid <= bus.i_valid;
            if (bus.i_valid) begin
                g     <= luma_sum[15:8];
                g_col <= col;
                g_row <= row;
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_comb begin
        col_new  = {lb1[g_col], lb0[g_col], g};
        win_next = {col_mid[23:16], col_right[23:16], col_new[23:16],
                    col_mid[15:8],  col_right[15:8],  col_new[15:8],
                    col_mid[7:0],   col_right[7:0],   col_new[7:0]};
        emit     = g_valid && (g_row >= RW'(2)) && (g_col >= CW'(2));
        last_pix = (g_row == RW'(IMG_H - 1)) && (g_col == CW'(IMG_W - 1));
    end

    // Line memories are never cleared; row gating keeps stale rows out of any window
    always_ff @(posedge clk) begin
        if (g_valid && !reset) begin
            lb1[g_col] <= lb0[g_col];
            lb0[g_col] <= g;
        end
    end

    // Only two past columns are held; the third comes straight from the line memories
    always_ff @(posedge clk) begin
        if (reset) begin
            col_mid          <= '0;
            col_right        <= '0;
            bus.o_window     <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_frame_done <= 1'b0;
        end else begin
            bus.o_valid      <= emit;
            bus.o_frame_done <= emit && last_pix;
            if (g_valid) begin
                col_mid   <= col_right;
                col_right <= col_new;
                if (emit) begin
                    bus.o_window <= win_next;
                end
            end
        end
    end
endmodule

// File: doc/gray_window3x3.md
# gray_window3x3

Downstream stage of the line buffer. Consumes the raster stream of 24-bit RGB pixels it produces, converts each pixel to 8-bit luma, and keeps two line memories of luma. For every pixel that completes a fully interior 3x3 neighbourhood, it emits that 3x3 luma window, feeding the convolution/filter stages that follow.

## Interface
- IMG_W, 64: pixels per line (≥3)
- IMG_H, 64: lines per frame (≥3)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_img  in  24  RGB pixel: R=[23:16], G=[15:8], B=[7:0]
- i_valid  in  1  i_img carries the next raster pixel this cycle (no backpressure)
- o_window  out  72  3x3 luma window, row-major, top row first: [71:64]=top-left … [7:0]=bottom-right
- o_valid  out  1  o_window valid this cycle
- o_frame_done  out  1  one-cycle pulse with the last window of a frame

## Operation
- Stage 1 (gray), on i_valid: g = (77*R + 150*G + 29*B) >> 8.
  - 16-bit unsigned sum; max 65280, so g ≤ 255 and there is no saturation.
  - Registers g, g_valid, plus the pixel's col/row.
- Position counters advance once per g_valid beat:
  - col runs 0..IMG_W-1. At IMG_W-1 it wraps to 0 and row increments.
  - row runs 0..IMG_H-1. At (IMG_H-1, IMG_W-1) both wrap to 0 and the next beat starts a new frame.
- Line memories lb0 (previous row) and lb1 (two rows back), each IMG_W x 8, indexed by col. On g_valid:
  - new window column = {lb1[col], lb0[col], g};
  - write lb1[col] ← lb0[col], lb0[col] ← g (read-before-write, same cycle);
  - window registers shift one column left, and the new column enters at the right.
- Output gating:
  - o_valid = g_valid && row ≥ 2 && col ≥ 2.
  - The window is centred on (row-1, col-1). Border pixels produce no output.
  - Outputs per frame = (IMG_W-2)*(IMG_H-2).
- o_frame_done = o_valid && row == IMG_H-1 && col == IMG_W-1.
- No cross-line contamination: when col < 2, the window registers still hold the previous row's tail, but output is gated off.
- Line memory contents are never cleared. Stale data is unreachable because of the row ≥ 2 gating after reset or at frame start.

## Timing
- Latency: o_valid/o_window assert exactly 2 cycles after the i_valid beat that completes the window.
  - cycle t: pixel accepted;
  - t+1: g registered;
  - t+2: window registered and outputs driven.
- Throughput: one pixel per cycle, sustained indefinitely. Back-to-back frames need no gap.
- i_valid low: counters, line memories and window registers hold. o_valid and o_frame_done are 0 for the corresponding cycle (2 cycles later).
- o_window holds its last value while o_valid = 0.
- Reset, including mid-frame:
  - one asserted cycle clears col, row, g_valid, window registers and all outputs (o_window = 0, o_valid = 0, o_frame_done = 0);
  - in-flight beats are discarded;
  - i_valid is ignored while reset is high;
  - the first beat after release is pixel (0,0).
- Simultaneous reset and i_valid: reset wins.

## Test plan
- Reset: reset high for 3 cycles with i_valid = 1 and random i_img → o_valid, o_frame_done and o_window stay 0 during reset and for 2 cycles after release.
- Luma: IMG_W = IMG_H = 4, all pixels 0xFF0000 → exactly 4 windows, every byte 0x4C. Repeat with 0x00FF00 → 0x95, 0x0000FF → 0x1C, 0xFFFFFF → 0xFF.
- Ordering: 4x4 frame, pixel (r,c) with R=G=B=16r+c → first window 0x00_01_02_10_11_12_20_21_22, driven 2 cycles after pixel (2,2) is accepted. Windows then follow for (2,3), (3,2) and (3,3). The last window is 0x11_12_13_21_22_23_31_32_33, and o_frame_done pulses with it.
- Gaps: same frame with i_valid randomly low about 40% of the time → identical window sequence, each exactly 2 cycles after its completing beat, no extra o_valid.
- Back-to-back frames: two 4x4 frames, second frame values +0x40, no idle → 8 windows and 2 o_frame_done pulses. Second-frame windows contain only second-frame values.
- Mid-frame reset: reset after pixel (2,1) is accepted, then a full 4x4 frame → exactly 4 windows matching the ordering test, with no output from the aborted frame.
